// File: rtl/uart8_rx_controller.sv
// Sequencing and buffering controller for the 16x-oversampled 8-bit UART receiver.
// Turns level-held done/err into events, queues bytes, tracks errors and line idle.
module uart8_rx_controller #(
    parameter int FIFO_DEPTH         = 4,
    parameter int ERR_RECOVER_TICKS  = 64,
    parameter int RECOVER_LEN        = 2,
    parameter int IDLE_TIMEOUT_TICKS = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxBusy,
    input  logic       rxDone,
    input  logic       rxErr,
    input  logic [7:0] rxData,
    output logic       rxEn,
    output logic [7:0] dataOut,
    output logic       dataValid,
    input  logic       dataReady,
    output logic       overflow,
    output logic [7:0] errCount,
    input  logic       clearStatus,
    output logic       idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = $clog2(ERR_RECOVER_TICKS + 1);
    localparam int RW = $clog2(RECOVER_LEN + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT_TICKS + 1);

    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_RECOVER_TICKS - 1);
    localparam logic [RW-1:0] REC_LAST  = RW'(RECOVER_LEN - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_DISABLED = 2'd0;
    localparam logic [1:0] S_ENABLING = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_RECOVER  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          done_q;
    logic          err_q;
    logic [EW-1:0] err_run;
    logic [RW-1:0] rec_cnt;
    logic [IW-1:0] idle_cnt;
    logic          idle_armed;

    logic in_run;
    logic push_evt;
    logic err_evt;
    logic err_hit;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    assign in_run    = (state == S_RUN);
    assign rxEn      = (state == S_ENABLING) || in_run;
    assign push_evt  = in_run && rxDone && !done_q;
    assign err_evt   = in_run && rxErr && !err_q;
    assign err_hit   = in_run && rxErr && (err_run == ERR_LAST);
    assign full      = (count == DEPTH);
    assign dataValid = (count != '0);
    assign pop       = dataValid && dataReady;
    assign push_ok   = push_evt && (!full || pop);
    assign drop      = push_evt && full && !pop;
    assign dataOut   = dataValid ? mem[rd_ptr] : 8'h00;

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = S_DISABLED;
        end else begin
            case (state)
                S_DISABLED: state_next = S_ENABLING;
                S_ENABLING: state_next = S_RUN;
                S_RUN:      if (err_hit) state_next = S_RECOVER;
                S_RECOVER:  if (rec_cnt == REC_LAST) state_next = S_ENABLING;
                default:    state_next = S_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DISABLED;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_run    <= '0;
            rec_cnt    <= '0;
            idle_cnt   <= '0;
            idle_armed <= 1'b0;
            idle       <= 1'b0;
            overflow   <= 1'b0;
            errCount   <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            state  <= state_next;
            // Masking with rxEn keeps a level held across a disable from re-firing.
            done_q <= rxEn && rxDone;
            err_q  <= rxEn && rxErr;

            if (in_run && rxErr && state_next == S_RUN) begin
                err_run <= err_run + 1'b1;
            end else begin
                err_run <= '0;
            end

            if (state == S_RECOVER && state_next == S_RECOVER) begin
                rec_cnt <= rec_cnt + 1'b1;
            end else begin
                rec_cnt <= '0;
            end

            if (push_ok) begin
                mem[wr_ptr] <= rxData;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (clearStatus) begin
                overflow <= drop;
            end else if (drop) begin
                overflow <= 1'b1;
            end

            if (clearStatus) begin
                errCount <= {7'b0, err_evt};
            end else if (err_evt && errCount != 8'hFF) begin
                errCount <= errCount + 1'b1;
            end

            idle <= 1'b0;
            if (push_ok) begin
                idle_armed <= 1'b1;
                idle_cnt   <= '0;
            end else if (!in_run) begin
                idle_armed <= 1'b0;
                idle_cnt   <= '0;
            end else if (idle_armed) begin
                if (rxBusy) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    idle       <= 1'b1;
                    idle_armed <= 1'b0;
                    idle_cnt   <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart8_rx_controller.sv
// Scoreboard bench for uart8_rx_controller: a queue-level model predicts
// accepted bytes, drops, error count and idle pulses; a monitor checks output.
module tb_uart8_rx_controller;

    localparam int D  = 4;
    localparam int TO = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rxBusy = 1'b0;
    logic       rxDone = 1'b0;
    logic       rxErr = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       rxEn;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       dataReady = 1'b0;
    logic       overflow;
    logic [7:0] errCount;
    logic       clearStatus = 1'b0;
    logic       idle;

    uart8_rx_controller dut (
        .clk(clk), .rst(rst), .enable(enable), .rxBusy(rxBusy),
        .rxDone(rxDone), .rxErr(rxErr), .rxData(rxData), .rxEn(rxEn),
        .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
        .overflow(overflow), .errCount(errCount),
        .clearStatus(clearStatus), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    byte unsigned exp_q[$];
    int  occ = 0;
    bit  exp_ovf = 0;
    int  exp_err = 0;
    bit  exp_idle = 0;
    bit  idle_armed_m = 0;
    int  idle_t = 0;
    bit  in_run = 0;
    bit  err_prev = 0;
    bit  push_now = 0;
    int  cyc = 0;
    int  idle_pulses = 0;
    int  idle_cyc = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock edge; the model applies the spec rules to the inputs seen there.
    task automatic tick();
        bit pop_m, acc, drop_m, ee;
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            occ = 0; exp_ovf = 0; exp_err = 0; exp_idle = 0;
            idle_armed_m = 0; idle_t = 0; err_prev = 0;
        end else begin
            pop_m  = dataReady && (occ > 0);
            acc    = push_now && ((occ < D) || pop_m);
            drop_m = push_now && !acc;
            if (acc) exp_q.push_back(rxData);
            occ = occ + int'(acc) - int'(pop_m);
            if (clearStatus) exp_ovf = drop_m;
            else if (drop_m) exp_ovf = 1;
            ee = in_run && rxErr && !err_prev;
            if (clearStatus) exp_err = int'(ee);
            else if (ee && exp_err < 255) exp_err++;
            err_prev = in_run && rxErr;
            exp_idle = 0;
            if (acc) begin
                idle_armed_m = 1; idle_t = 0;
            end else if (!in_run) begin
                idle_armed_m = 0; idle_t = 0;
            end else if (idle_armed_m) begin
                if (rxBusy) idle_t = 0;
                else begin
                    idle_t++;
                    if (idle_t == TO) begin
                        exp_idle = 1; idle_armed_m = 0; idle_t = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic start_byte(input byte unsigned b);
        rxDone = 1'b1; rxData = b; push_now = in_run;
        tick();
        push_now = 0;
    endtask

    task automatic finish_byte(input int gap);
        repeat (15) tick();
        rxDone = 1'b0; rxData = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic rtick(input int rd_pct);
        dataReady   = ($urandom_range(0, 99) < rd_pct);
        rxBusy      = ($urandom_range(0, 7) == 0);
        clearStatus = ($urandom_range(0, 15) == 0);
        tick();
        clearStatus = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_rxEn", rxEn, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_dataValid", dataValid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_errCount", errCount, 0);
        check("rst_idle", idle, 0);
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick();
        check("enabling_rxEn", rxEn, 1);
        tick();
        check("run_rxEn", rxEn, 1);
        in_run = 1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("valid", dataValid, occ != 0);
            if (!dataValid) check("out_zero", dataOut, 0);
            if (dataValid && dataReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", dataOut, 32'hFFFF_FFFF);
                end else begin
                    check("data", dataOut, exp_q.pop_front());
                end
            end
            check("idle", idle, exp_idle);
            if (idle === 1'b1) begin
                idle_pulses++;
                idle_cyc = cyc;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, limit 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        tick(); tick();
        check_reset();
        rst = 1'b0;

        // Single byte, one-cycle latency, then host pop.
        start_run();
        start_byte(8'hA5);
        check("t1_valid", dataValid, 1);
        check("t1_data", dataOut, 8'hA5);
        dataReady = 1'b1;
        finish_byte(2);
        check("t1_drained", dataValid, 0);

        // Five bytes into a four-deep FIFO.
        dataReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            start_byte(8'(i));
            finish_byte(1);
        end
        check("t2_overflow", overflow, 1);
        check("t2_head", dataOut, 8'h01);
        dataReady = 1'b1;
        repeat (6) tick();
        check("t2_drained", dataValid, 0);
        dataReady = 1'b0;
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        check("t2_clear", overflow, 0);

        // Push into a full FIFO while the host pops.
        for (int i = 0; i < 4; i++) begin
            start_byte(8'h10 + 8'(i));
            finish_byte(1);
        end
        dataReady = 1'b1;
        start_byte(8'h14);
        check("t3_no_overflow", overflow, 0);
        finish_byte(2);
        check("t3_drained", dataValid, 0);

        // Idle timeout, then restart by an rxBusy pulse at tick 100.
        idle_pulses = 0;
        start_byte(8'h5A);
        t0 = cyc;
        finish_byte(200);
        check("t5_pulses", idle_pulses, 1);
        check("t5_at160", idle_cyc - t0, TO);
        idle_pulses = 0;
        start_byte(8'h5B);
        t0 = cyc;
        repeat (15) tick();
        rxDone = 1'b0;
        repeat (84) tick();
        rxBusy = 1'b1;
        tick();
        rxBusy = 1'b0;
        repeat (200) tick();
        check("t5_restart_pulses", idle_pulses, 1);
        check("t5_restart_at", idle_cyc - t0, 100 + TO);

        // Held error forces a receiver recovery.
        dataReady = 1'b0;
        rxErr = 1'b1;
        repeat (63) tick();
        check("t4_rxEn_63", rxEn, 1);
        tick();
        in_run = 0;
        check("t4_recover1", rxEn, 0);
        check("t4_errCount", errCount, 1);
        rxErr = 1'b0;
        tick();
        check("t4_recover2", rxEn, 0);
        tick();
        check("t4_enabling", rxEn, 1);
        tick();
        check("t4_run", rxEn, 1);
        in_run = 1;
        start_byte(8'h77);
        check("t4_byte_after", dataOut, 8'h77);
        finish_byte(1);
        dataReady = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 300; i++) begin
            rxErr = 1'b1; tick();
            rxErr = 1'b0; tick();
        end
        check("t4_saturate", errCount, 255);
        check("t4_model_err", errCount, exp_err);
        rxErr = 1'b1;
        clearStatus = 1'b1;
        tick();
        check("t4_clear_edge", errCount, 1);
        clearStatus = 1'b0;
        rxErr = 1'b0;
        tick();

        // Disable mid-byte with two bytes queued.
        dataReady = 1'b0;
        start_byte(8'h61); finish_byte(1);
        start_byte(8'h62); finish_byte(1);
        rxBusy = 1'b1;
        enable = 1'b0;
        tick();
        in_run = 0;
        check("t6_disabled", rxEn, 0);
        check("t6_kept", dataOut, 8'h61);
        rxBusy = 1'b0;
        dataReady = 1'b1;
        repeat (3) tick();
        check("t6_drained", dataValid, 0);
        dataReady = 1'b0;
        start_run();
        for (int i = 0; i < 3; i++) begin
            start_byte(8'h70 + 8'(i));
            finish_byte(1);
        end
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        in_run = 0;
        tick();
        check_reset();
        rst = 1'b0;

        // Randomised traffic against the model.
        start_run();
        for (int n = 0; n < 60; n++) begin
            int rd_pct;
            rd_pct = $urandom_range(5, 95);
            rxDone = 1'b1;
            rxData = 8'($urandom);
            push_now = 1;
            rtick(rd_pct);
            push_now = 0;
            repeat (15) rtick(rd_pct);
            rxDone = 1'b0;
            repeat ($urandom_range(1, 20)) rtick(rd_pct);
            check("rnd_overflow", overflow, exp_ovf);
            check("rnd_errCount", errCount, exp_err);
        end
        rxBusy = 1'b0;
        clearStatus = 1'b0;
        dataReady = 1'b1;
        repeat (8) tick();
        check("end_empty", dataValid, 0);
        check("end_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
